masked_sbox_table_writer: RTL and testbench

- Fills one bank of a masked S-box BRAM with a re-masked table: T[x ^ m_in] = S[x] ^ m_out.
- Reads the unmasked S-box (or an existing table) from a registered-output source ROM port.
- Writes the result through the write port of the 9Kb dual-port S-box BRAM (8-bit data, 10-bit address, top 2 bits select the bank).
- Used to refresh mask pairs between encryptions while the other banks stay in use by the round pipeline.

---
 rtl/masked_sbox_table_writer_if.sv | 29 ++
 rtl/masked_sbox_table_writer.sv | 100 ++++++++++
 tb/tb_masked_sbox_table_writer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/masked_sbox_table_writer_if.sv
// Control, source-ROM read and destination-BRAM write signals of the masked
// S-box table writer, bundled for the controller (master) and writer (slave).
interface masked_sbox_table_writer_if #(
  parameter int BANK_W = 2
);
  logic              start;
  logic [7:0]        m_in;
  logic [7:0]        m_out;
  logic [BANK_W-1:0] bank;
  logic              busy;
  logic              done;
  logic [7:0]        SRC_ADDR;
  logic              SRC_EN;
  logic [7:0]        SRC_DO;
  logic [8+BANK_W-1:0] WR_ADDR;
  logic [7:0]        WR_DI;
  logic              WR_EN;
  logic              WR_WE;

  modport master (
    output start, m_in, m_out, bank, SRC_DO,
    input  busy, done, SRC_ADDR, SRC_EN, WR_ADDR, WR_DI, WR_EN, WR_WE
  );

  modport slave (
    input  start, m_in, m_out, bank, SRC_DO,
    output busy, done, SRC_ADDR, SRC_EN, WR_ADDR, WR_DI, WR_EN, WR_WE
  );
endinterface

// File: rtl/masked_sbox_table_writer.sv
// Rewrites one bank of the masked S-box BRAM as T[x ^ m_in] = S[x] ^ m_out,
// streaming the source ROM through a SRC_LATENCY-deep address/valid pipe.
module masked_sbox_table_writer #(
  parameter int SRC_LATENCY = 2,
  parameter int BANK_W      = 2
) (
  input  logic clk,
  input  logic rst,
  masked_sbox_table_writer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        m_in_q, m_in_d;
  logic [7:0]        m_out_q, m_out_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  logic [SRC_LATENCY-1:0]      vld_pipe_q;
  logic [SRC_LATENCY-1:0][7:0] x_pipe_q;
  logic                        issue;
  logic                        wr_vld;

  assign issue = (state_q == S_READ);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    m_in_d  = m_in_q;
    m_out_d = m_out_q;
    bank_d  = bank_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_in_d  = bus.m_in;
          m_out_d = bus.m_out;
          bank_d  = bus.bank;
          x_d     = 8'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // x wraps to 0 here, so it doubles as the drain cycle counter
        x_d = x_q + 8'd1;
        if (x_q == 8'hFF) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        x_d = x_q + 8'd1;
        if (x_q == 8'(SRC_LATENCY - 1)) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= 8'd0;
      m_in_q  <= 8'd0;
      m_out_q <= 8'd0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_in_q  <= m_in_d;
      m_out_q <= m_out_d;
      bank_q  <= bank_d;
    end
  end

  // Delay line matching the ROM latency: the tail stage lines up with SRC_DO.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      x_pipe_q   <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      x_pipe_q[0]   <= x_q;
      for (int i = 1; i < SRC_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        x_pipe_q[i]   <= x_pipe_q[i-1];
      end
    end
  end

  assign wr_vld = vld_pipe_q[SRC_LATENCY-1];

  assign bus.busy     = (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_FIN);
  assign bus.SRC_EN   = (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.SRC_ADDR = issue ? x_q : 8'd0;

  assign bus.WR_EN   = wr_vld;
  assign bus.WR_WE   = wr_vld;
  assign bus.WR_ADDR = wr_vld ? {bank_q, x_pipe_q[SRC_LATENCY-1] ^ m_in_q} : '0;
  assign bus.WR_DI   = wr_vld ? (bus.SRC_DO ^ m_out_q) : 8'd0;
endmodule

// File: tb/tb_masked_sbox_table_writer.sv
// Directed bench: AES S-box source ROMs feed two writers (latency 2 and 1);
// each scenario captures a cycle trace and checks it against hand timing.
module tb_masked_sbox_table_writer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] m_in, m_out;
  logic [1:0] bank;

  always #5 clk = ~clk;

  masked_sbox_table_writer_if #(.BANK_W(2)) ifa ();
  masked_sbox_table_writer_if #(.BANK_W(2)) ifb ();

  assign ifa.start = start;  assign ifb.start = start;
  assign ifa.m_in  = m_in;   assign ifb.m_in  = m_in;
  assign ifa.m_out = m_out;  assign ifb.m_out = m_out;
  assign ifa.bank  = bank;   assign ifb.bank  = bank;

  masked_sbox_table_writer #(.SRC_LATENCY(2), .BANK_W(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  masked_sbox_table_writer #(.SRC_LATENCY(1), .BANK_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [7:0] sbox [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  // Source ROMs: registered address plus output register (A), output register only (B)
  logic [7:0] ra0, ra1, rb0;
  always @(posedge clk) begin
    ra0 <= sbox[ifa.SRC_ADDR];
    ra1 <= ra0;
    rb0 <= sbox[ifb.SRC_ADDR];
  end
  assign ifa.SRC_DO = ra1;
  assign ifb.SRC_DO = rb0;

  int total = 0;
  int bad   = 0;

  logic       c_we   [600];
  logic       c_en   [600];
  logic       c_busy [600];
  logic       c_done [600];
  logic       c_sen  [600];
  logic [7:0] c_sa   [600];
  logic [9:0] c_addr [600];
  logic [7:0] c_di   [600];

  // Raises start mid-cycle k, then records cycles k+1..k+n at each negedge.
  task automatic capture(input int sel, input int n, input int clr_at, input int pulse_at,
                         input int chg_at, input logic [7:0] nmi, input logic [7:0] nmo,
                         input logic [1:0] nb, input int rst_at);
    start = 1'b1;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (sel == 0) begin
        c_we[j] = ifa.WR_WE; c_en[j] = ifa.WR_EN; c_busy[j] = ifa.busy; c_done[j] = ifa.done;
        c_sen[j] = ifa.SRC_EN; c_sa[j] = ifa.SRC_ADDR; c_addr[j] = ifa.WR_ADDR; c_di[j] = ifa.WR_DI;
      end else begin
        c_we[j] = ifb.WR_WE; c_en[j] = ifb.WR_EN; c_busy[j] = ifb.busy; c_done[j] = ifb.done;
        c_sen[j] = ifb.SRC_EN; c_sa[j] = ifb.SRC_ADDR; c_addr[j] = ifb.WR_ADDR; c_di[j] = ifb.WR_DI;
      end
      if (j == clr_at) start = 1'b0;
      if (pulse_at != 0 && j == pulse_at) start = 1'b1;
      if (pulse_at != 0 && j == pulse_at + 1) start = 1'b0;
      if (j == chg_at) begin m_in = nmi; m_out = nmo; bank = nb; end
      if (rst_at != 0 && j == rst_at) rst = 1'b1;
      if (rst_at != 0 && j == rst_at + 1) rst = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; m_in = 8'd0; m_out = 8'd0; bank = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ifa.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", ifa.busy); end
    total++; if (ifa.done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", ifa.done); end
    total++; if (ifa.SRC_EN !== 1'b0)    begin bad++; $display("FAIL reset_src_en got=%b exp=0", ifa.SRC_EN); end
    total++; if (ifa.SRC_ADDR !== 8'd0)  begin bad++; $display("FAIL reset_src_addr got=%h exp=00", ifa.SRC_ADDR); end
    total++; if (ifa.WR_EN !== 1'b0)     begin bad++; $display("FAIL reset_wr_en got=%b exp=0", ifa.WR_EN); end
    total++; if (ifa.WR_WE !== 1'b0)     begin bad++; $display("FAIL reset_wr_we got=%b exp=0", ifa.WR_WE); end
    total++; if (ifa.WR_ADDR !== 10'd0)  begin bad++; $display("FAIL reset_wr_addr got=%h exp=000", ifa.WR_ADDR); end
    total++; if (ifa.WR_DI !== 8'd0)     begin bad++; $display("FAIL reset_wr_di got=%h exp=00", ifa.WR_DI); end
    total++; if (ifb.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy_l1 got=%b exp=0", ifb.busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Plain copy, bank 2: writes at k+3..k+258, done at k+259.
  task automatic test_copy(input string nm, input int pulse_at);
    logic ew, eb, ed;
    m_in = 8'h00; m_out = 8'h00; bank = 2'd2;
    capture(0, 262, 1, pulse_at, pulse_at, 8'hA5, 8'h99, 2'd0, 0);
    for (int j = 1; j <= 262; j++) begin
      ew = (j >= 3 && j <= 258); eb = (j <= 258); ed = (j == 259);
      total++; if (c_we[j] !== ew || c_en[j] !== ew)
        begin bad++; $display("FAIL %s_we cyc=%0d got=%b/%b exp=%b", nm, j, c_we[j], c_en[j], ew); end
      total++; if (c_busy[j] !== eb || c_sen[j] !== eb)
        begin bad++; $display("FAIL %s_busy cyc=%0d got=%b/%b exp=%b", nm, j, c_busy[j], c_sen[j], eb); end
      total++; if (c_done[j] !== ed)
        begin bad++; $display("FAIL %s_done cyc=%0d got=%b exp=%b", nm, j, c_done[j], ed); end
      if (j <= 256) begin
        total++; if (c_sa[j] !== 8'(j-1))
          begin bad++; $display("FAIL %s_src_addr cyc=%0d got=%h exp=%h", nm, j, c_sa[j], 8'(j-1)); end
      end
      if (ew) begin
        total++; if (c_addr[j] !== {2'd2, 8'(j-3)} || c_di[j] !== sbox[j-3])
          begin bad++; $display("FAIL %s_write cyc=%0d got=%h/%h exp=%h/%h", nm, j, c_addr[j], c_di[j], {2'd2, 8'(j-3)}, sbox[j-3]); end
      end
    end
    total++; if (c_addr[3] !== 10'h200 || c_di[3] !== 8'h63)
      begin bad++; $display("FAIL %s_first got=%h/%h exp=200/63", nm, c_addr[3], c_di[3]); end
    total++; if (c_addr[86] !== 10'h253 || c_di[86] !== 8'hED)
      begin bad++; $display("FAIL %s_x53 got=%h/%h exp=253/ed", nm, c_addr[86], c_di[86]); end
  endtask

  task automatic test_masked;
    int hits [256];
    int nw;
    m_in = 8'h5A; m_out = 8'h3C; bank = 2'd1;
    capture(0, 262, 1, 0, 0, 8'h00, 8'h00, 2'd0, 0);
    total++; if (c_addr[3] !== 10'h15A || c_di[3] !== 8'h5F)
      begin bad++; $display("FAIL masked_first got=%h/%h exp=15a/5f", c_addr[3], c_di[3]); end
    total++; if (c_addr[4] !== 10'h15B || c_di[4] !== 8'h40)
      begin bad++; $display("FAIL masked_second got=%h/%h exp=15b/40", c_addr[4], c_di[4]); end
    total++; if (c_done[259] !== 1'b1)
      begin bad++; $display("FAIL masked_done got=%b exp=1", c_done[259]); end
    for (int a = 0; a < 256; a++) hits[a] = 0;
    nw = 0;
    for (int j = 1; j <= 262; j++) begin
      if (c_we[j] === 1'b1) begin
        nw++;
        total++; if (c_addr[j][9:8] !== 2'd1)
          begin bad++; $display("FAIL masked_bank cyc=%0d got=%h exp=1xx", j, c_addr[j]); end
        hits[c_addr[j][7:0]]++;
        total++; if (c_di[j] !== (sbox[c_addr[j][7:0] ^ 8'h5A] ^ 8'h3C))
          begin bad++; $display("FAIL masked_data cyc=%0d got=%h exp=%h", j, c_di[j], sbox[c_addr[j][7:0] ^ 8'h5A] ^ 8'h3C); end
      end
    end
    total++; if (nw != 256) begin bad++; $display("FAIL masked_count got=%0d exp=256", nw); end
    for (int a = 0; a < 256; a++) begin
      total++; if (hits[a] != 1) begin bad++; $display("FAIL masked_hits addr=%h got=%0d exp=1", a, hits[a]); end
    end
  endtask

  task automatic test_reset_mid;
    int nw;
    m_in = 8'h0F; m_out = 8'hF0; bank = 2'd3;
    capture(0, 110, 1, 0, 0, 8'h00, 8'h00, 2'd0, 100);
    total++; if (c_we[100] !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", c_we[100]); end
    for (int j = 101; j <= 110; j++) begin
      total++; if (c_we[j] !== 1'b0 || c_sen[j] !== 1'b0 || c_busy[j] !== 1'b0 || c_done[j] !== 1'b0)
        begin bad++; $display("FAIL rstmid_quiet cyc=%0d got=%b%b%b%b exp=0000", j, c_we[j], c_sen[j], c_busy[j], c_done[j]); end
    end
    capture(0, 262, 1, 0, 0, 8'h00, 8'h00, 2'd0, 0);
    nw = 0;
    for (int j = 1; j <= 262; j++) begin
      if (c_we[j] === 1'b1) begin
        nw++;
        total++; if (c_addr[j] !== {2'd3, 8'(j-3) ^ 8'h0F} || c_di[j] !== (sbox[j-3] ^ 8'hF0))
          begin bad++; $display("FAIL rstmid_write cyc=%0d got=%h/%h", j, c_addr[j], c_di[j]); end
      end
    end
    total++; if (nw != 256) begin bad++; $display("FAIL rstmid_count got=%0d exp=256", nw); end
    total++; if (c_done[259] !== 1'b1) begin bad++; $display("FAIL rstmid_done got=%b exp=1", c_done[259]); end
  endtask

  // Latency 1: writes at k+2..k+257, done at k+258.
  task automatic test_latency1;
    logic ew;
    m_in = 8'h00; m_out = 8'h00; bank = 2'd2;
    capture(1, 262, 1, 0, 0, 8'h00, 8'h00, 2'd0, 0);
    for (int j = 1; j <= 262; j++) begin
      ew = (j >= 2 && j <= 257);
      total++; if (c_we[j] !== ew)
        begin bad++; $display("FAIL lat1_we cyc=%0d got=%b exp=%b", j, c_we[j], ew); end
      total++; if (c_done[j] !== (j == 258) || c_busy[j] !== (j <= 257))
        begin bad++; $display("FAIL lat1_ctl cyc=%0d got=%b/%b", j, c_done[j], c_busy[j]); end
      if (ew) begin
        total++; if (c_addr[j] !== {2'd2, 8'(j-2)} || c_di[j] !== sbox[j-2])
          begin bad++; $display("FAIL lat1_write cyc=%0d got=%h/%h exp=%h/%h", j, c_addr[j], c_di[j], {2'd2, 8'(j-2)}, sbox[j-2]); end
      end
    end
  endtask

  // Start held through FIN: second run accepted at edge k+260, masks changed at k+10.
  task automatic test_back_to_back;
    logic ew1, ew2;
    m_in = 8'h00; m_out = 8'h00; bank = 2'd2;
    capture(0, 525, 261, 0, 10, 8'h5A, 8'h3C, 2'd1, 0);
    for (int j = 1; j <= 525; j++) begin
      ew1 = (j >= 3 && j <= 258);
      ew2 = (j >= 263 && j <= 518);
      total++; if (c_we[j] !== (ew1 || ew2))
        begin bad++; $display("FAIL b2b_we cyc=%0d got=%b exp=%b", j, c_we[j], ew1 || ew2); end
      total++; if (c_done[j] !== (j == 259 || j == 519))
        begin bad++; $display("FAIL b2b_done cyc=%0d got=%b", j, c_done[j]); end
      total++; if (c_busy[j] !== ((j <= 258) || (j >= 261 && j <= 518)))
        begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b", j, c_busy[j]); end
      if (ew1) begin
        total++; if (c_addr[j] !== {2'd2, 8'(j-3)} || c_di[j] !== sbox[j-3])
          begin bad++; $display("FAIL b2b_first cyc=%0d got=%h/%h", j, c_addr[j], c_di[j]); end
      end
      if (ew2) begin
        total++; if (c_addr[j] !== {2'd1, 8'(j-263) ^ 8'h5A} || c_di[j] !== (sbox[j-263] ^ 8'h3C))
          begin bad++; $display("FAIL b2b_second cyc=%0d got=%h/%h", j, c_addr[j], c_di[j]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_copy("copy", 0);
    test_masked();
    test_copy("ignore", 49);
    test_reset_mid();
    test_latency1();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
